// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong game engine control path.
//   - engine state codes reported by the game state machine
//   - match_sequencer state codes (also driven out on seq_state)
//   - default frame-count and debounce constants
//   - saturating decrement helper for frame countdowns
package pong_pkg;

  // Engine state codes as seen on engine_state.
  typedef enum logic [2:0] {
    ENG_INIT       = 3'b001,
    ENG_INIT_POINT = 3'b010,
    ENG_RUN_POINT  = 3'b011,
    ENG_POINT_OVER = 3'b101,
    ENG_GAME_OVER  = 3'b110
  } eng_state_e;

  // Sequencer state codes. SEQ_PAUSED is unreachable without SEQ_PAUSE_EN.
  typedef enum logic [2:0] {
    SEQ_IDLE       = 3'b000,
    SEQ_SERVE_WAIT = 3'b001,
    SEQ_PLAY       = 3'b010,
    SEQ_PAUSED     = 3'b011,
    SEQ_GO_HOLD    = 3'b100
  } seq_state_e;

  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [7:0]  DEF_SERVE_FRAMES    = 8'd60;
  localparam logic [7:0]  DEF_GAMEOVER_FRAMES = 8'd180;

  // Countdowns never wrap below zero.
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

endpackage

// File: rtl/match_sequencer_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and press-edge detector
// for one raw push button.
//   clk      in  system clock
//   reset    in  asynchronous, active-high reset
//   btn_i    in  raw button level (asynchronous)
//   press_o  out one-cycle pulse on each rising edge of the debounced level
// The debounced level follows the synchronized input once it has been seen
// different from the current level for DEBOUNCE_CYCLES consecutive samples.
// press_o is registered one cycle after the debounced level rises.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q;
  logic        level_prev_q;
  logic        press_q;
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= 16'd0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= 16'd0;
      end else if (({1'b0, cnt_q} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES}) begin
        // This sample completes the required run of differing samples.
        level_q <= sync2_q;
        cnt_q   <= 16'd0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: frame-rate scheduler and match controller for pong.
//   clk           in  system clock
//   reset         in  asynchronous, active-high reset
//   frame_clk     in  VGA frame clock (asynchronous, synchronized here)
//   btn_start     in  raw start button
//   btn_pause     in  raw pause button (used only with SEQ_PAUSE_EN)
//   engine_state  in  engine state code (see pong_pkg::eng_state_e)
//   engine_start  out one-cycle start_game pulse to the engine
//   engine_step   out one-cycle update enable, at most one per frame
//   paused        out high while in PAUSED
//   serve_count   out remaining frames of the current countdown
//   seq_state     out sequencer state (see pong_pkg::seq_state_e)
// Build option: define SEQ_PAUSE_EN to include the pause debouncer and the
// PAUSED state; otherwise btn_pause is ignored and paused stays 0.
// Handshake: there is no ready/valid back-pressure; engine_start and
// engine_step are single-cycle strobes the engine must accept when high.
module match_sequencer
  import pong_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [7:0]  SERVE_FRAMES    = DEF_SERVE_FRAMES,
  parameter logic [7:0]  GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [2:0] engine_state,
  output logic       engine_start,
  output logic       engine_step,
  output logic       paused,
  output logic [7:0] serve_count,
  output logic [2:0] seq_state
);

  // Frame clock: two sync flops, one history flop, registered tick.
  // The tick is therefore seen 3 clk after the frame_clk rising edge.
  logic fsync1_q, fsync2_q, fsync3_q, tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsync1_q <= 1'b0;
      fsync2_q <= 1'b0;
      fsync3_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      fsync1_q <= frame_clk;
      fsync2_q <= fsync1_q;
      fsync3_q <= fsync2_q;
      tick_q   <= fsync2_q & ~fsync3_q;
    end
  end

  logic start_press;
  logic pause_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_start),
    .press_o(start_press)
  );

`ifdef SEQ_PAUSE_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_pause),
    .press_o(pause_press)
  );
`else
  logic unused_btn_pause;
  assign unused_btn_pause = btn_pause;
  assign pause_press      = 1'b0;
`endif

  seq_state_e state_q;
  logic [7:0] count_q;
  logic       start_q;
  logic       step_q;
  logic       paused_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEQ_IDLE;
      count_q  <= 8'd0;
      start_q  <= 1'b0;
      step_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      step_q  <= 1'b0;
      case (state_q)
        SEQ_IDLE: begin
          if (start_press) begin
            start_q <= 1'b1;
            count_q <= SERVE_FRAMES;
            state_q <= SEQ_SERVE_WAIT;
          end
        end
        SEQ_SERVE_WAIT: begin
          if (tick_q) begin
            count_q <= sat_dec(count_q);
            // Last frame of the serve delay (or an empty delay): serve now.
            if (count_q <= 8'd1) begin
              start_q <= 1'b1;
              state_q <= SEQ_PLAY;
            end
          end
        end
        SEQ_PLAY: begin
          // Engine transitions outrank the pause press, which outranks the
          // step; leaving PLAY drops the step for that tick.
          if (engine_state == ENG_INIT_POINT) begin
            count_q <= SERVE_FRAMES;
            state_q <= SEQ_SERVE_WAIT;
          end else if (engine_state == ENG_GAME_OVER) begin
            count_q <= GAMEOVER_FRAMES;
            state_q <= SEQ_GO_HOLD;
          end else if (engine_state == ENG_INIT) begin
            state_q <= SEQ_IDLE;
`ifdef SEQ_PAUSE_EN
          end else if (pause_press) begin
            state_q  <= SEQ_PAUSED;
            paused_q <= 1'b1;
`endif
          end else if (tick_q && (engine_state == ENG_RUN_POINT)) begin
            step_q <= 1'b1;
          end
        end
`ifdef SEQ_PAUSE_EN
        SEQ_PAUSED: begin
          if (pause_press) begin
            state_q  <= SEQ_PLAY;
            paused_q <= 1'b0;
          end
        end
`endif
        SEQ_GO_HOLD: begin
          if (tick_q) begin
            count_q <= sat_dec(count_q);
            if (count_q <= 8'd1) begin
              state_q <= SEQ_IDLE;
            end
          end
        end
        default: begin
          state_q  <= SEQ_IDLE;
          paused_q <= 1'b0;
        end
      endcase
    end
  end

  assign engine_start = start_q;
  assign engine_step  = step_q;
  assign paused       = paused_q;
  assign serve_count  = count_q;
  assign seq_state    = state_q;

endmodule
